// File: rtl/simple_alu_stream.sv
// simple_alu_stream: streaming ALU that applies a latched op to a job of len operand pairs
module simple_alu_stream #(
  parameter int DataWidth = 32,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           alu_config_i,
  input  logic [CntWidth-1:0]  len_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [DataWidth-1:0] res_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]           state, state_nxt, op;
  logic [CntWidth-1:0]  len, in_cnt, out_cnt;
  logic [DataWidth-1:0] res, result;
  logic                 out_valid, in_hs, out_hs, last_out;
  assign in_ready_o  = (state == RUN) && (in_cnt < len) && (!out_valid || out_ready_i);
  assign in_hs       = in_valid_i && in_ready_o;
  assign out_hs      = out_valid && out_ready_i;
  assign last_out    = out_hs && (out_cnt == len - CntWidth'(1));
  assign busy_o      = state == RUN;
  assign done_o      = state == DONE;
  assign res_o       = res;
  assign out_valid_o = out_valid;
  // Latched op applied to the operand pair currently offered
  always_comb
    result = (op == 2'b00) ? a_i + b_i :
             (op == 2'b01) ? a_i - b_i :
             (op == 2'b10) ? a_i * b_i : a_i ^ b_i;
  // Job sequencing: IDLE -> RUN (or straight to DONE for an empty job) -> DONE -> IDLE
  always_comb
    state_nxt = (state == IDLE) ? (start_i ? ((len_i != '0) ? RUN : DONE) : IDLE) :
                (state == RUN)  ? (last_out ? DONE : RUN) : IDLE;
  // Job parameters, counters and the single-stage result register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      op        <= 2'b00;
      len       <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      res       <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_i) begin
        op      <= alu_config_i;
        len     <= len_i;
        in_cnt  <= '0;
        out_cnt <= '0;
      end
      if (in_hs) begin
        in_cnt <= in_cnt + CntWidth'(1);
        res    <= result;
      end
      if (out_hs) out_cnt <= out_cnt + CntWidth'(1);
      out_valid <= in_hs || (out_valid && !out_ready_i);
    end
  end
endmodule

// File: tb/tb_simple_alu_stream.sv
// tb_simple_alu_stream: directed checks of the streaming ALU job flow
module tb_simple_alu_stream;
  logic        clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
  logic [1:0]  alu_config_i = 2'b00;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, in_ready_o, out_valid_o;
  logic [31:0] a_i = '0, b_i = '0, res_o;
  logic        in_valid_i = 1'b0, out_ready_i = 1'b0;
  int          errors = 0, checks = 0;
  simple_alu_stream dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .alu_config_i(alu_config_i), .len_i(len_i),
    .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .a_i(a_i), .b_i(b_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .res_o(res_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic idle_outs(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_rdy"}, in_ready_o, 0);
    chk({tag, "_vld"}, out_valid_o, 0);
    chk({tag, "_res"}, res_o, 0);
  endtask
  task automatic start(input logic [1:0] cfg, input logic [15:0] len, input string tag);
    start_i = 1'b1; alu_config_i = cfg; len_i = len;
    #1;
    tick();
    start_i = 1'b0;
    chk({tag, "_busy"}, busy_o, 1);
  endtask
  task automatic pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input string tag);
    in_valid_i = 1'b1; a_i = a; b_i = b;
    #1;
    chk({tag, "_rdy"}, in_ready_o, 1);
    tick();
    chk({tag, "_vld"}, out_valid_o, 1);
    chk(tag, res_o, exp);
  endtask
  task automatic finish_job(input string tag);
    in_valid_i = 1'b0;
    #1;
    chk({tag, "_rdy_end"}, in_ready_o, 0);
    tick();
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_vld_end"}, out_valid_o, 0);
    tick();
    chk({tag, "_done_clr"}, done_o, 0);
  endtask
  initial begin
    int acc, oi, dn;
    logic [31:0] hold;
    logic stalled;
    #3;
    idle_outs("rst");
    #9 rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    idle_outs("idle");
    out_ready_i = 1'b1;
    start(2'b00, 16'd3, "add");
    pair(32'd1, 32'd2, 32'd3, "add0");
    pair(32'hFFFFFFFF, 32'd1, 32'd0, "add1");
    pair(32'd7, 32'd8, 32'd15, "add2");
    finish_job("add");
    start(2'b01, 16'd2, "sub");
    pair(32'd5, 32'd7, 32'hFFFFFFFE, "sub0");
    pair(32'd10, 32'd3, 32'd7, "sub1");
    finish_job("sub");
    start(2'b10, 16'd1, "mul");
    pair(32'h10000, 32'h10000, 32'd0, "mul0");
    finish_job("mul");
    start(2'b11, 16'd1, "xor");
    pair(32'hF0F0, 32'h0FF0, 32'hFF00, "xor0");
    finish_job("xor");
    start(2'b00, 16'd4, "bp");
    acc = 0; oi = 0; dn = 0; hold = '0;
    in_valid_i = 1'b1; b_i = 32'd100;
    for (int c = 0; c < 40 && dn == 0; c++) begin
      out_ready_i = (c % 2) == 0;
      a_i = acc;
      #1;
      stalled = out_valid_o && !out_ready_i;
      if (stalled) begin
        chk("bp_stall_rdy", in_ready_o, 0);
        hold = res_o;
      end
      if (out_valid_o && out_ready_i) begin
        chk("bp_res", res_o, 100 + oi);
        oi++;
      end
      if (in_ready_o && in_valid_i) acc++;
      tick();
      if (stalled) begin
        chk("bp_hold_res", res_o, hold);
        chk("bp_hold_vld", out_valid_o, 1);
      end
      if (done_o) dn = 1;
    end
    chk("bp_done_seen", dn, 1);
    chk("bp_out_count", oi, 4);
    chk("bp_in_count", acc, 4);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    tick();
    chk("bp_done_clr", done_o, 0);
    in_valid_i = 1'b1;
    start_i = 1'b1; alu_config_i = 2'b00; len_i = 16'd0;
    #1;
    chk("len0_rdy0", in_ready_o, 0);
    chk("len0_done0", done_o, 0);
    tick();
    start_i = 1'b0;
    chk("len0_done1", done_o, 1);
    chk("len0_busy1", busy_o, 0);
    chk("len0_rdy1", in_ready_o, 0);
    chk("len0_vld1", out_valid_o, 0);
    tick();
    chk("len0_done2", done_o, 0);
    chk("len0_rdy2", in_ready_o, 0);
    chk("len0_vld2", out_valid_o, 0);
    in_valid_i = 1'b0;
    start(2'b00, 16'd2, "ign");
    start_i = 1'b1; alu_config_i = 2'b11; len_i = 16'd5;
    pair(32'd3, 32'd4, 32'd7, "ign0");
    start_i = 1'b0; alu_config_i = 2'b10;
    pair(32'd6, 32'd1, 32'd7, "ign1");
    finish_job("ign");
    for (int i = 0; i < 3; i++) tick();
    chk("ign_no_2nd_done", done_o, 0);
    chk("ign_no_restart", busy_o, 0);
    start(2'b00, 16'd5, "rstj");
    pair(32'd1, 32'd1, 32'd2, "rstj0");
    pair(32'd2, 32'd2, 32'd4, "rstj1");
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    idle_outs("async_rst");
    tick();
    idle_outs("held_rst");
    rst_ni = 1'b1;
    tick();
    idle_outs("after_rst");
    start(2'b01, 16'd1, "post");
    pair(32'd9, 32'd4, 32'd5, "post0");
    finish_job("post");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
